alu_sequencer: RTL

- Initiator side of the ALU operand/result interface. Accepts one 16-bit instruction word per handshake and decodes it.
- Reads operands from an internal 8x16 register file and drives the ALU operand/control inputs.
- Waits for the combinational ALU to settle, then writes `ALU_out` back to the register addressed by `Addr_out` and latches the five compare flags.
- Sits between instruction fetch and the ALU in the 16-bit CPU datapath.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU datapath:
// instruction fields, ALU output types, sequencer states and flag order.
package cpu_pkg;

    localparam logic [1:0] OT_AM    = 2'b00;
    localparam logic [1:0] OT_ARITH = 2'b01;
    localparam logic [1:0] OT_LOGIC = 2'b10;
    localparam logic [1:0] OT_NONE  = 2'b11;

    localparam int OT_HI   = 15;
    localparam int OT_LO   = 14;
    localparam int OPC_HI  = 13;
    localparam int OPC_LO  = 10;
    localparam int RA_HI   = 9;
    localparam int RA_LO   = 7;
    localparam int RB_HI   = 6;
    localparam int RB_LO   = 4;
    localparam int IMM_SEL = 3;
    localparam int IMM_HI  = 2;
    localparam int IMM_LO  = 0;

    localparam int FLG_ZA = 4;
    localparam int FLG_ZB = 3;
    localparam int FLG_EQ = 2;
    localparam int FLG_GT = 1;
    localparam int FLG_LT = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } seq_state_t;

    function automatic logic [4:0] pack_flags(
        input logic za, input logic zb, input logic eq,
        input logic gt, input logic lt
    );
        logic [4:0] f;
        f         = '0;
        f[FLG_ZA] = za;
        f[FLG_ZB] = zb;
        f[FLG_EQ] = eq;
        f[FLG_GT] = gt;
        f[FLG_LT] = lt;
        return f;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two async read ports, a debug read
// port, one synchronous write port, asynchronously cleared on reset.
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] ra_addr_i,
    output logic [DW-1:0] ra_data_o,
    input  logic [RW-1:0] rb_addr_i,
    output logic [DW-1:0] rb_data_o,
    input  logic [RW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o,
    input  logic          we_i,
    input  logic [RW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [DW-1:0] rf_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i) begin
            rf_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o  = rf_q[ra_addr_i];
    assign rb_data_o  = rf_q[rb_addr_i];
    assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Initiator side of the ALU interface: accepts an instruction, drives
// operands from the register file and writes the settled result back.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int NREGS         = 8,
    parameter int DW            = 16,
    parameter int SETTLE_CYCLES = 1,
    localparam int RW           = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [DW-1:0] op1,
    output logic [DW-1:0] op2,
    output logic [DW-1:0] op1_regaddr,
    output logic [DW-1:0] op2_regaddr,
    output logic [3:0]    ALU_opcode,
    output logic [1:0]    ALU_OT,
    input  logic [DW-1:0] ALU_out,
    input  logic [DW-1:0] Addr_out,
    input  logic          za,
    input  logic          zb,
    input  logic          eq,
    input  logic          gt,
    input  logic          lt,
    output logic [4:0]    flags,
    output logic          done,
    output logic          err,
    input  logic [RW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    seq_state_t    state_q, state_d;
    logic [15:0]   instr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    flags_q;
    logic [DW-1:0] op1_q, op2_q, op1_ra_q, op2_ra_q;
    logic [3:0]    opc_q;
    logic [1:0]    ot_q;

    logic [RW-1:0] ra, rb;
    logic [DW-1:0] ra_data, rb_data, op2_sel;
    logic          accept, addr_oor, wb_fail, wr_en;

    assign ra = instr_q[RA_HI:RA_LO];
    assign rb = instr_q[RB_HI:RB_LO];
    assign op2_sel = instr_q[IMM_SEL] ? DW'(instr_q[IMM_HI:IMM_LO])
                                      : rb_data;

    assign accept   = instr_valid && instr_ready;
    assign addr_oor = (Addr_out[DW-1:RW] != '0);
    assign wb_fail  = (instr_q[OT_HI:OT_LO] == OT_NONE) || addr_oor;
    assign wr_en    = (state_q == S_WB) && !wb_fail;

    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra_addr_i  (ra),
        .ra_data_o  (ra_data),
        .rb_addr_i  (rb),
        .rb_data_o  (rb_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (wr_en),
        .wa_i       (Addr_out[RW-1:0]),
        .wd_i       (ALU_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WB: begin
                done    = 1'b1;
                err     = wb_fail;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) instr_q <= instr;
            if (wr_en)  flags_q <= pack_flags(za, zb, eq, gt, lt);
        end
    end

    // Operands are registered once in ISSUE and held until the next ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q    <= '0;
            op2_q    <= '0;
            op1_ra_q <= '0;
            op2_ra_q <= '0;
            opc_q    <= '0;
            ot_q     <= '0;
        end else if (state_q == S_ISSUE) begin
            op1_q    <= ra_data;
            op2_q    <= op2_sel;
            op1_ra_q <= DW'(ra);
            op2_ra_q <= DW'(rb);
            opc_q    <= instr_q[OPC_HI:OPC_LO];
            ot_q     <= instr_q[OT_HI:OT_LO];
        end
    end

    assign op1         = op1_q;
    assign op2         = op2_q;
    assign op1_regaddr = op1_ra_q;
    assign op2_regaddr = op2_ra_q;
    assign ALU_opcode  = opc_q;
    assign ALU_OT      = ot_q;
    assign flags       = flags_q;

endmodule
